// File: rtl/memory_access_stage.sv
// ---------------------------------------------------------------------------
// memory_access_stage
//
// Memory stage of the 16-bit pipelined CPU. Takes the ExecuteMemory register
// outputs, performs loads/stores over a req/ack data-memory handshake, stalls
// upstream while an access is outstanding and presents registered results to
// the MemoryWriteback register.
//
// Ports:
//   clk, rst_n            pipeline clock, asynchronous active-low reset
//   in_valid              ExecuteMemory register holds a live instruction
//   wbs_in, ni_in         writeback select / flag forwarded to writeback
//   mm_in, wm_in          load / store request
//   alu_result_in         ALU result, low ADDR_W bits are the memory address
//   mem_data_in           store data
//   stall_out             hold ExecuteMemory and upstream registers
//   mem_req/we/addr/wdata data-memory request, held stable until mem_ack
//   mem_rdata, mem_ack    load data and request completion
//   valid_out             one-cycle pulse: writeback outputs are new
//   wbs_out, ni_out, alu_result_out, rd_data_out  registered writeback fields
//   err_timeout           sticky flag: an access was aborted by the timeout
// ---------------------------------------------------------------------------
module memory_access_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              wbs_in,
    input  logic              mm_in,
    input  logic              wm_in,
    input  logic              ni_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              valid_out,
    output logic              wbs_out,
    output logic              ni_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] rd_data_out,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Abort fires on the edge at which the counter would reach TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wbs_l_q, wbs_l_d;
    logic              ni_l_q, ni_l_d;
    logic              load_l_q, load_l_d;
    logic [DATA_W-1:0] alu_l_q, alu_l_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              valid_q, valid_d;
    logic              wbs_out_q, wbs_out_d;
    logic              ni_out_q, ni_out_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              err_q, err_d;

    // Next-state, handshake and writeback-field computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wbs_l_d     = wbs_l_q;
        ni_l_d      = ni_l_q;
        load_l_d    = load_l_q;
        alu_l_d     = alu_l_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        valid_d     = 1'b0;
        wbs_out_d   = wbs_out_q;
        ni_out_d    = ni_out_q;
        alu_out_d   = alu_out_q;
        rd_d        = rd_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    wbs_l_d  = wbs_in;
                    ni_l_d   = ni_in;
                    alu_l_d  = alu_result_in;
                    // A combined load+store is executed as a store only.
                    load_l_d = mm_in & ~wm_in;
                    if (wm_in || mm_in) begin
                        state_d     = ACCESS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = wm_in;
                        mem_addr_d  = alu_result_in[ADDR_W-1:0];
                        mem_wdata_d = mem_data_in;
                    end else begin
                        valid_d   = 1'b1;
                        wbs_out_d = wbs_in;
                        ni_out_d  = ni_in;
                        alu_out_d = alu_result_in;
                        rd_d      = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // Ack is checked first so it wins over a simultaneous timeout.
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    valid_d   = 1'b1;
                    wbs_out_d = wbs_l_q;
                    ni_out_d  = ni_l_q;
                    alu_out_d = alu_l_q;
                    rd_d      = load_l_q ? mem_rdata : '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    valid_d   = 1'b1;
                    wbs_out_d = wbs_l_q;
                    ni_out_d  = ni_l_q;
                    alu_out_d = alu_l_q;
                    rd_d      = '0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wbs_l_q     <= 1'b0;
            ni_l_q      <= 1'b0;
            load_l_q    <= 1'b0;
            alu_l_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            valid_q     <= 1'b0;
            wbs_out_q   <= 1'b0;
            ni_out_q    <= 1'b0;
            alu_out_q   <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wbs_l_q     <= wbs_l_d;
            ni_l_q      <= ni_l_d;
            load_l_q    <= load_l_d;
            alu_l_q     <= alu_l_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            valid_q     <= valid_d;
            wbs_out_q   <= wbs_out_d;
            ni_out_q    <= ni_out_d;
            alu_out_q   <= alu_out_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
        end
    end

    assign stall_out      = (state_q == ACCESS);
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign valid_out      = valid_q;
    assign wbs_out        = wbs_out_q;
    assign ni_out         = ni_out_q;
    assign alu_result_out = alu_out_q;
    assign rd_data_out    = rd_q;
    assign err_timeout    = err_q;

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Memory stage of the 16-bit pipelined CPU; consumes the ExecuteMemory pipeline-register outputs and issues loads/stores to data memory over a req/ack handshake.
- Stalls upstream while an access is outstanding, then presents registered results to the MemoryWriteback register.
- Replaces the single-cycle memory assumption so slow or shared data memory works without changing the execute stage.

Parameters:
- DATA_W, 16, width of data and ALU result
- ADDR_W, 16, width of the data-memory address (low ADDR_W bits of alu_result_in)
- TIMEOUT, 255, max cycles in ACCESS before abort; counter width = clog2(TIMEOUT+1)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ExecuteMemory register holds a live instruction
- wbs_in  in  1  writeback select (0 = ALU result, 1 = memory read data)
- mm_in  in  1  memory read (load) request
- wm_in  in  1  memory write (store) request
- ni_in  in  1  flag forwarded unchanged to writeback
- alu_result_in  in  DATA_W  ALU result / memory address
- mem_data_in  in  DATA_W  store data
- stall_out  out  1  hold ExecuteMemory and upstream registers
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  data-memory address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- mem_ack  in  1  memory completes the request
- valid_out  out  1  one-cycle pulse: writeback outputs are new
- wbs_out  out  1  registered wbs
- ni_out  out  1  registered ni
- alu_result_out  out  DATA_W  registered ALU result
- rd_data_out  out  DATA_W  registered load data
- err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; FSM in IDLE; timeout counter 0.
  - Takes effect immediately, including mid-ACCESS: mem_req drops without waiting for an edge.
- FSM states: IDLE, ACCESS.
- stall_out = (state == ACCESS). Combinational from state only; never depends on in_valid or mem_ack.
- Acceptance: on a rising edge with state == IDLE and in_valid = 1, latch wbs, ni, alu_result, mem_data, wm, mm.
- Acceptance, no memory op (wm = 0, mm = 0):
  - Next edge: valid_out = 1, alu_result_out/wbs_out/ni_out updated, rd_data_out = 0.
  - State stays IDLE. Latency 1; back-to-back accepts allowed every cycle.
- Acceptance, memory op (wm = 1 or mm = 1):
  - Next edge: state -> ACCESS, mem_req = 1, mem_we = wm, mem_addr = alu_result[ADDR_W-1:0], mem_wdata = mem_data_in, counter cleared.
  - valid_out = 0 that cycle.
- wm = 1 and mm = 1 together: treated as a store; rd_data_out = 0.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until a mem_ack = 1 is sampled.
  - Counter increments each cycle without ack.
- ACCESS, edge with mem_ack = 1:
  - mem_req -> 0, state -> IDLE, valid_out = 1, latched fields go to the outputs.
  - rd_data_out = mem_rdata for a load, 0 for a store.
  - Minimum load/store latency: 2 edges from acceptance to valid_out.
- ACCESS, counter reaches TIMEOUT with no ack:
  - mem_req -> 0, state -> IDLE, valid_out = 1, rd_data_out = 0.
  - err_timeout set to 1; sticky until reset.
  - If mem_ack arrives on the same edge the counter hits TIMEOUT, the ack wins: normal completion, no error.
- mem_ack while in IDLE: ignored, no output change.
- in_valid while in ACCESS: ignored. Upstream holds the instruction because stall_out = 1; it is accepted on the first IDLE edge.
- Returning to IDLE: the edge that leaves ACCESS does not accept. A pending instruction is accepted on the following edge (one bubble after each memory op).
- Output holding:
  - valid_out is a single-cycle pulse.
  - Data outputs hold their last values until the next completion.

Test Plan:
1. Reset mid-ACCESS: assert rst_n=0 asynchronously between edges while mem_req=1 -> mem_req, stall_out and all outputs 0 immediately; FSM in IDLE after rst_n release.
2. ALU pass-through: in_valid=1, wm=mm=0, alu_result_in=0x0005, wbs=0, ni=1 for 3 consecutive cycles with values 5, 6, 7 -> valid_out pulses on each following edge; alu_result_out = 5, 6, 7; stall_out never 1; mem_req never 1.
3. Load with 3-cycle ack: mm=1, wbs=1, alu_result_in=0x0050 -> mem_req=1, mem_we=0, mem_addr=0x0050 and stall_out=1 for 3 cycles; mem_ack with mem_rdata=0x1234 -> valid_out=1, rd_data_out=0x1234, wbs_out=1, stall_out=0.
4. Store with immediate ack: wm=1, alu_result_in=0x0007, mem_data_in=0x00FF, mem_ack=1 in the first ACCESS cycle -> mem_we=1, mem_wdata=0x00FF; valid_out 2 edges after acceptance; rd_data_out=0.
5. Timeout with TIMEOUT=4: load, mem_ack held 0 -> after 4 ACCESS cycles mem_req drops, valid_out=1, rd_data_out=0, err_timeout=1 and remains 1 through subsequent normal ops until rst_n.
6. Stall hold and edge cases: load followed by an ALU op held by upstream during stall -> ALU op accepted exactly one edge after load completion, completes 1 cycle later. Separately: stray mem_ack in IDLE causes no change; wm=mm=1 performs a write only.
